ifetch_queue: RTL

//  Instruction fetch front end feeding the 16-bit instruction decoder. Fetches

---
 rtl/ifetch_queue.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/ifetch_queue.sv
// Instruction fetch front end: word fetch, parcel split, prefetch queue.
// Presents 16-bit parcels with pc/fault to the decoder; handles redirects.
module ifetch_queue #(
    parameter int              RV       = 32,
    parameter int              QDEPTH   = 4,
    parameter logic [RV-1:0]   RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    output logic          mem_req,
    output logic [RV-3:0] mem_addr,
    input  logic          mem_ack,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_fault,
    input  logic          redirect,
    input  logic [RV-1:0] redirect_pc,
    output logic [15:0]   ins,
    output logic          idone,
    output logic [RV-1:0] ins_pc,
    output logic          ins_fault,
    input  logic          ins_take
);

    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DISC = 2'd2;
    localparam logic [1:0] S_HALT = 2'd3;

    logic [1:0]    state;
    logic [RV-3:0] word;
    logic          skip_low;
    logic [RV-3:0] req_addr;
    logic [AW-1:0] rp;
    logic [AW-1:0] wp;
    logic [CW-1:0] count;

    logic [15:0]   q_ins [QDEPTH];
    logic [RV-1:0] q_pc  [QDEPTH];
    logic          q_flt [QDEPTH];

    logic          empty;
    logic          pop;
    logic          ack_ok;
    logic          can_issue;
    logic [1:0]    push_n;
    logic [15:0]   e0_ins;
    logic [RV-1:0] e0_pc;
    logic          e0_flt;
    logic [15:0]   e1_ins;
    logic [RV-1:0] e1_pc;
    logic          unused_ok;

    assign unused_ok = redirect_pc[0];

    assign empty     = (count == '0);
    assign pop       = !empty && ins_take;
    assign ack_ok    = (state == S_WAIT) && mem_ack;
    assign can_issue = (count <= CW'(QDEPTH - 2));

    assign mem_req   = (state == S_WAIT) || (state == S_DISC);
    assign mem_addr  = req_addr;
    assign idone     = !empty;
    assign ins       = empty ? 16'h0 : q_ins[rp];
    assign ins_pc    = empty ? '0 : q_pc[rp];
    assign ins_fault = empty ? 1'b0 : q_flt[rp];

    // Build the one or two entries produced by an accepted response.
    always_comb begin
        push_n = 2'd0;
        e0_ins = 16'h0;
        e0_pc  = {word, 2'b00};
        e0_flt = 1'b0;
        e1_ins = mem_rdata[31:16];
        e1_pc  = {word, 2'b10};
        if (ack_ok) begin
            if (mem_fault) begin
                push_n = 2'd1;
                e0_flt = 1'b1;
            end else if (skip_low) begin
                push_n = 2'd1;
                e0_ins = mem_rdata[31:16];
                e0_pc  = {word, 2'b10};
            end else begin
                push_n = 2'd2;
                e0_ins = mem_rdata[15:0];
            end
        end
    end

    // Queue storage; a redirect discards any same-cycle push.
    always_ff @(posedge clk) begin
        if (!reset && !redirect) begin
            if (push_n != 2'd0) begin
                q_ins[wp] <= e0_ins;
                q_pc[wp]  <= e0_pc;
                q_flt[wp] <= e0_flt;
            end
            if (push_n == 2'd2) begin
                q_ins[wp + AW'(1)] <= e1_ins;
                q_pc[wp + AW'(1)]  <= e1_pc;
                q_flt[wp + AW'(1)] <= 1'b0;
            end
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset || redirect) begin
            rp    <= '0;
            wp    <= '0;
            count <= '0;
        end else begin
            wp    <= wp + AW'(push_n);
            rp    <= rp + AW'(pop);
            count <= count + CW'(push_n) - CW'(pop);
        end
    end

    // Fetch sequencer: one outstanding request, never withdrawn.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_RUN;
            word     <= RESET_PC[RV-1:2];
            skip_low <= RESET_PC[1];
            req_addr <= RESET_PC[RV-1:2];
        end else if (redirect) begin
            word     <= redirect_pc[RV-1:2];
            skip_low <= redirect_pc[1];
            if (mem_req && !mem_ack)
                state <= S_DISC;
            else
                state <= S_RUN;
        end else begin
            unique case (state)
                S_RUN: begin
                    if (can_issue) begin
                        state    <= S_WAIT;
                        req_addr <= word;
                    end
                end
                S_WAIT: begin
                    if (mem_ack) begin
                        if (mem_fault) begin
                            state <= S_HALT;
                        end else begin
                            state    <= S_RUN;
                            word     <= word + (RV-2)'(1);
                            skip_low <= 1'b0;
                        end
                    end
                end
                S_DISC: begin
                    if (mem_ack)
                        state <= S_RUN;
                end
                default: state <= S_HALT;
            endcase
        end
    end

endmodule
